// File: rtl/fft_pkg.sv
// fft_pkg: shared types and constants for the FFT frame sequencer
package fft_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT, S_DONE} fft_seq_state_t;
  localparam int FFT_FRAME_LEN = 4096;
  localparam int FFT_SAMPLE_W = 8;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/fft_hold_buffer.sv
// fft_hold_buffer: single-entry valid/ready register; a push that cannot land is flagged as a drop
module fft_hold_buffer import fft_pkg::*; #(
  parameter int DW = FFT_SAMPLE_W
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          hs_o,
  output logic          drop_o
);
  logic          valid_q, valid_d, load;
  logic [DW-1:0] data_q, data_d;
  always_comb begin
    hs_o    = valid_q & ready_i;
    load    = push_i & (~valid_q | hs_o);
    drop_o  = push_i & ~load;
    valid_d = load | (valid_q & ~ready_i);
    data_d  = load ? data_i : data_q;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: decimates samples into FFT frames, tags index/last, waits for FFT frame completion
module fft_frame_sequencer import fft_pkg::*; #(
  parameter int WIDTH     = FFT_SAMPLE_W,
  parameter int FRAME_LEN = FFT_FRAME_LEN,
  parameter int DECIMATE  = 1,
  parameter int TIMEOUT   = 1000000
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         enable_in,
  input  logic [WIDTH-1:0]             sample_in,
  input  logic                         sample_valid_in,
  input  logic                         fft_ready_in,
  output logic [WIDTH-1:0]             fft_sample_out,
  output logic                         fft_sample_valid_out,
  output logic                         fft_sample_last_out,
  output logic [$clog2(FRAME_LEN)-1:0] window_index_out,
  input  logic                         fft_out_valid_in,
  input  logic                         fft_out_last_in,
  output logic                         frame_start_out,
  output logic                         frame_done_out,
  output logic                         busy_out,
  output logic                         timeout_out,
  output logic [15:0]                  drop_count_out
);
  localparam int IW = $clog2(FRAME_LEN);
  localparam int DW = WIDTH + IW + 1;
  fft_seq_state_t state_q, state_d;
  logic [7:0]       phase_q, phase_d, phase_nx;
  logic [IW-1:0]    idx_q, idx_d, load_idx, hold_idx;
  logic [31:0]      to_q, to_d;
  logic [15:0]      drop_q, drop_d;
  logic             tout_q, tout_d, start_q, start_d, drop_ev;
  logic             accept, push, hs, buf_drop, hold_valid, hold_last;
  logic [WIDTH-1:0] hold_data;
  logic [DW-1:0]    hold_q;
  assign accept   = sample_valid_in && phase_q == '0;
  assign phase_nx = !sample_valid_in ? phase_q : (phase_q == 8'(DECIMATE - 1)) ? '0 : phase_q + 8'd1;
  assign load_idx = idx_q + IW'(hs);
  // once the frame's last sample is held, further accepts are drops even if it drains now
  assign push     = state_q == S_FILL && accept && !(hold_valid && hold_last);
  fft_hold_buffer #(.DW(DW)) u_hold (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push_i (push),
    .data_i ({load_idx == IW'(FRAME_LEN - 1), load_idx, sample_in}),
    .ready_i(fft_ready_in),
    .valid_o(hold_valid),
    .data_o (hold_q),
    .hs_o   (hs),
    .drop_o (buf_drop)
  );
  assign {hold_last, hold_idx, hold_data} = hold_q;
  always_comb begin
    state_d = state_q;
    phase_d = '0;
    idx_d   = idx_q;
    to_d    = '0;
    tout_d  = tout_q;
    drop_ev = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = enable_in ? S_FILL : S_IDLE;
        idx_d   = '0;
      end
      S_FILL: begin
        phase_d = phase_nx;
        idx_d   = load_idx;
        drop_ev = (accept && hold_valid && hold_last) || buf_drop;
        state_d = (hs && hold_last) ? S_WAIT : S_FILL;
      end
      S_WAIT: begin
        phase_d = phase_nx;
        drop_ev = accept;
        to_d    = to_q + 32'd1;
        if (fft_out_valid_in && fft_out_last_in) state_d = S_DONE;
        else if (to_q == 32'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          tout_d  = 1'b1;
        end
      end
      default: begin
        state_d = enable_in ? S_FILL : S_IDLE;
        idx_d   = '0;
      end
    endcase
    drop_d  = drop_ev ? sat_inc(drop_q) : drop_q;
    start_d = push && !buf_drop && load_idx == '0;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      to_q    <= '0;
      drop_q  <= '0;
      tout_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
      drop_q  <= drop_d;
      tout_q  <= tout_d;
      start_q <= start_d;
    end
  end
  assign fft_sample_out       = hold_data;
  assign fft_sample_valid_out = hold_valid;
  assign fft_sample_last_out  = hold_last;
  assign window_index_out     = hold_idx;
  assign frame_start_out      = start_q;
  assign frame_done_out       = state_q == S_DONE;
  assign busy_out             = state_q != S_IDLE;
  assign timeout_out          = tout_q;
  assign drop_count_out       = drop_q;
endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
Sequences the audio sample stream into fixed-length FFT frames. Decimates incoming samples, tags each forwarded sample with its window index (drives the hanning coefficient lookup) and frame-last flag, and forwards it to the FFT input with a one-entry hold buffer against FFT backpressure. After a frame is loaded, it blocks input until the FFT output frame completes, then pulses frame_done so the peak finder result can be latched. Sits between the audio sample source and the hanning_window/fft chain.

Parameters:
WIDTH, 8, signed sample width.
FRAME_LEN, 4096, samples per frame; power of two, 8..65536.
DECIMATE, 1, forward one of every DECIMATE valid input samples; 1..255.
TIMEOUT, 1000000, maximum cycles in WAIT_FFT before abort.

Ports:
clk_in  in  1  system clock.
rst_in  in  1  synchronous, active-low reset.
enable_in  in  1  1 = run continuous frames; 0 = finish current frame, then idle.
sample_in  in  WIDTH  signed audio sample.
sample_valid_in  in  1  one-cycle strobe; sample_in valid.
fft_ready_in  in  1  FFT input tready.
fft_sample_out  out  WIDTH  sample to window/FFT.
fft_sample_valid_out  out  1  tvalid to window/FFT.
fft_sample_last_out  out  1  tlast; high with sample index FRAME_LEN-1.
window_index_out  out  $clog2(FRAME_LEN)  index of fft_sample_out within frame.
fft_out_valid_in  in  1  FFT output tvalid (observed only).
fft_out_last_in  in  1  FFT output tlast.
frame_start_out  out  1  one-cycle pulse when index 0 is forwarded.
frame_done_out  out  1  one-cycle pulse when FFT output frame completes.
busy_out  out  1  high in any state except IDLE.
timeout_out  out  1  sticky; set on WAIT_FFT timeout, cleared by reset only.
drop_count_out  out  16  saturating count of dropped samples.

Behaviour:
- Reset (rst_in low at a clock edge): state IDLE; all outputs 0; counters, hold buffer and decimation phase cleared. Reset mid-frame abandons the frame without a done pulse.
- States: IDLE, FILL, WAIT_FFT, DONE.
- IDLE -> FILL when enable_in=1. Index counter = 0, decimation phase = 0.
- FILL: each sample_valid_in advances the decimation phase; a sample is accepted when phase = 0, then phase wraps mod DECIMATE. Non-accepted decimated samples are not drops.
- Accepted sample is loaded into the hold register; fft_sample_valid_out rises the next cycle (latency 1). The output is held stable until fft_ready_in && fft_sample_valid_out; valid drops the cycle after the handshake unless a new sample is loaded that same cycle.
- Accepted sample while the hold register is full and not draining that cycle: sample dropped, drop_count_out += 1, saturating at 16'hFFFF.
- Simultaneous handshake and new accept: new sample replaces the hold register with no bubble.
- window_index_out and fft_sample_last_out are registered with the sample. Index increments per completed handshake.
- frame_start_out pulses in the cycle index-0 valid first asserts.
- Handshake on index FRAME_LEN-1 -> WAIT_FFT. The timeout counter clears on entry.
- WAIT_FFT: every sample_valid_in at decimation phase 0 counts as a drop. The decimation phase keeps running.
- WAIT_FFT, fft_out_valid_in && fft_out_last_in -> DONE.
- WAIT_FFT, timeout counter reaches TIMEOUT-1 -> IDLE; timeout_out set; no done pulse.
- DONE: frame_done_out high for exactly this one cycle. Next state is FILL if enable_in=1 (index=0), else IDLE.
- enable_in low during FILL or WAIT_FFT has no effect until DONE.
- fft_out_last_in seen outside WAIT_FFT is ignored.

Decomposition:
- Shared package fft_pkg: state enum fft_seq_state_t (2-bit), FRAME_LEN default constant, sample type width constant.
- One sub-module, fft_hold_buffer: single-entry valid/ready register with drop flag. The FSM, decimator and counters stay in the top module.

Test Plan:
- Bench parameters: FRAME_LEN=8, DECIMATE=1, fft_ready_in=1, strobe every 4 cycles, samples 1..8 -> outputs 1..8 with indices 0..7, valid 1 cycle after each strobe, last only on index 7, one frame_start pulse, state WAIT_FFT.
- In WAIT_FFT, pulse fft_out_valid_in&&fft_out_last_in -> frame_done_out high exactly 1 cycle; next frame index restarts at 0 with enable_in=1; with enable_in=0, returns to IDLE and busy_out=0.
- DECIMATE=3, 24 strobes of values 0..23 -> forwarded 0,3,6,...,21, indices 0..7, drop_count_out=0.
- Hold fft_ready_in=0 for 10 cycles while 3 back-to-back accepted strobes arrive -> first sample held stable, drop_count_out=2; on ready, first sample transfers and index advances by 1.
- TIMEOUT=20, no fft_out_last_in after the frame -> after 20 WAIT_FFT cycles: IDLE, timeout_out=1, no frame_done_out.
- Reset asserted at index 5 -> next cycle all outputs 0, state IDLE; after release the new frame starts at index 0.
